uim_fuse_loader: RTL

Serial configuration controller for the device's universal interconnect matrix (UIM). It shifts a fuse bitstream into a shadow register holding one 5-bit select field per UIM switch. After a complete frame it commits all fields atomically to the active select bus that drives the `template_uim` instances. Until the first successful commit, and after every reset, all switches sit in the erased (all-ones) state.

---
 rtl/uim_fuse_loader_pkg.sv | 18 +
 rtl/uim_fuse_loader_shadow.sv | 36 +++
 rtl/uim_fuse_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uim_fuse_loader_pkg.sv
// uim_pkg: shared constants and loader state encoding for uim_fuse_loader.
// The CHECK state exists only when UIM_FUSE_CHECK_EN is defined.
package uim_pkg;

  localparam int UIM_MUX_W = 5;
  localparam logic [UIM_MUX_W-1:0] UIM_ERASED = 5'b11111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
`ifdef UIM_FUSE_CHECK_EN
    CHECK  = 3'd2,
`endif
    COMMIT = 3'd3,
    DONE   = 3'd4
  } uim_ld_state_t;

endpackage

// File: rtl/uim_fuse_loader_shadow.sv
// uim_shadow_shift: shadow register for the incoming fuse frame.
// Shifts right with the new bit entering the MSB; preset wins over shift.
module uim_shadow_shift #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         preset,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (preset) begin
      data_d = '1;
    end else if (shift_en) begin
      data_d = {bit_in, data_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '1;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/uim_fuse_loader.sv
// uim_fuse_loader: serial fuse loader that commits a full frame of UIM selects atomically.
// Define UIM_FUSE_CHECK_EN to require a trailing even-parity bit checked before commit.
module uim_fuse_loader
  import uim_pkg::*;
#(
  parameter int NUM_UIM = 40,
  parameter int MUX_W   = UIM_MUX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_valid,
  input  logic                     cfg_bit,
  output logic                     cfg_ready,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [NUM_UIM*MUX_W-1:0] uim_mux_flat
);

  localparam int DATA_W = NUM_UIM * MUX_W;
  localparam int CNT_W  = $clog2(DATA_W + 2);
`ifdef UIM_FUSE_CHECK_EN
  localparam int FRAME_W = DATA_W + 1;
  localparam uim_ld_state_t AFTER_LOAD = CHECK;
`else
  localparam int FRAME_W = DATA_W;
  localparam uim_ld_state_t AFTER_LOAD = COMMIT;
`endif
  localparam logic [CNT_W-1:0]  CNT_DATA   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [DATA_W-1:0] ERASED_BUS = {NUM_UIM{UIM_ERASED}};

  uim_ld_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mux_q, mux_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sh_preset;
  logic              sh_shift;
  logic              accept;
  logic [DATA_W-1:0] shadow;
`ifdef UIM_FUSE_CHECK_EN
  logic              par_q, par_d;
  logic              err_q, err_d;
`endif

  uim_shadow_shift #(
    .W (DATA_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .preset   (sh_preset),
    .shift_en (sh_shift),
    .bit_in   (cfg_bit),
    .data_o   (shadow)
  );

  // The trailing parity bit (when present) is counted but never enters the shadow.
  assign sh_shift = accept && (cnt_q < CNT_DATA);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mux_d     = mux_q;
    sh_preset = 1'b0;
    accept    = 1'b0;
`ifdef UIM_FUSE_CHECK_EN
    par_d     = par_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        sh_preset = 1'b1;
        cnt_d     = '0;
`ifdef UIM_FUSE_CHECK_EN
        par_d     = 1'b0;
        if (cfg_start) begin
          err_d = 1'b0;
        end
`endif
        if (cfg_start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          sh_preset = 1'b1;
          cnt_d     = '0;
`ifdef UIM_FUSE_CHECK_EN
          par_d     = 1'b0;
`endif
        end else if (cfg_valid && ready_q) begin
          accept = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
`ifdef UIM_FUSE_CHECK_EN
          par_d  = par_q ^ cfg_bit;
`endif
          if (cnt_q == CNT_LAST) begin
            state_d = AFTER_LOAD;
          end
        end
      end
`ifdef UIM_FUSE_CHECK_EN
      // XOR over data plus parity bit is zero for a good even-parity frame.
      CHECK: begin
        if (par_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = COMMIT;
        end
      end
`endif
      COMMIT: begin
        mux_d   = shadow;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_d = (state_d == LOAD);
  assign busy_d  = (state_d != IDLE);
  assign done_d  = (state_d == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mux_q   <= ERASED_BUS;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UIM_FUSE_CHECK_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mux_q   <= mux_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UIM_FUSE_CHECK_EN
      par_q   <= par_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cfg_ready    = ready_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign uim_mux_flat = mux_q;
`ifdef UIM_FUSE_CHECK_EN
  assign cfg_err      = err_q;
`else
  assign cfg_err      = 1'b0;
`endif

endmodule
